approx_compressor_42c: RTL and testbench

//  Registered row of exact 4:2 compressors with carry-in/carry-out, used for

---
 rtl/approx_compressor_42c_pkg.sv | 9 +
 rtl/approx_compressor_42c_cell.sv | 36 +++
 rtl/approx_compressor_42c.sv | 92 +++++++++
 tb/tb_approx_compressor_42c.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/approx_compressor_42c_pkg.sv
// approx_compressor_42c_pkg
//   Shared constants for the 4:2 compressor row.
//   DEFAULT_LANES : column count used when the top is instantiated without
//                   an explicit LANES override (legal range 1..32).
package approx_compressor_42c_pkg;

  localparam int DEFAULT_LANES = 8;

endpackage

// File: rtl/approx_compressor_42c_cell.sv
// comp42_cell
//   Combinational exact 4:2 compressor for one column.
//   Five weight-1 inputs are reduced to one weight-1 bit and two weight-2 bits.
//   Ports:
//     x1..x4 : in  operand bits of this column
//     ci     : in  lateral carry from the previous column
//     sum    : out weight-1 result bit
//     carry  : out weight-2 result bit kept in this column's output
//     co     : out weight-2 lateral carry for the next column
module comp42_cell (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic ci,
  output logic sum,
  output logic carry,
  output logic co
);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic s1;

  // First full adder sees only x1..x3, so co never depends on ci and the row
  // has no ripple path; the second full adder folds in x4 and the lateral ci.
  always_comb begin
    s1    = x1 ^ x2 ^ x3;
    co    = maj3(x1, x2, x3);
    sum   = s1 ^ x4 ^ ci;
    carry = maj3(s1, x4, ci);
  end

endmodule

// File: rtl/approx_compressor_42c.sv
// approx_compressor_42c
//   Registered row of LANES chained exact 4:2 compressors for partial-product
//   reduction. Each column's co feeds the next column's ci.
//   Ports:
//     clk       : in  rising-edge clock
//     rst       : in  synchronous active-high reset
//     in_valid  : in  qualifies x1..x4 and cin
//     x1..x4    : in  [LANES] operand bits, one per column
//     cin       : in  lateral carry into column 0
//     out_valid : out registered copy of in_valid
//     sum       : out [LANES] per-column sum bit, weight 2^k
//     carry     : out [LANES] per-column carry bit, weight 2^(k+1)
//     cout      : out lateral carry out of the last column, weight 2^LANES
module approx_compressor_42c
  import approx_compressor_42c_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LANES-1:0] x1,
  input  logic [LANES-1:0] x2,
  input  logic [LANES-1:0] x3,
  input  logic [LANES-1:0] x4,
  input  logic             cin,
  output logic             out_valid,
  output logic [LANES-1:0] sum,
  output logic [LANES-1:0] carry,
  output logic             cout
);

  // chain[k] is the lateral carry into column k; chain[LANES] leaves the row.
  logic [LANES:0]   chain;
  logic [LANES-1:0] sum_c;
  logic [LANES-1:0] carry_c;

  assign chain[0] = cin;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    comp42_cell u_cell (
      .x1    (x1[k]),
      .x2    (x2[k]),
      .x3    (x3[k]),
      .x4    (x4[k]),
      .ci    (chain[k]),
      .sum   (sum_c[k]),
      .carry (carry_c[k]),
      .co    (chain[k+1])
    );
  end

  logic [LANES-1:0] sum_q,   sum_d;
  logic [LANES-1:0] carry_q, carry_d;
  logic             cout_q,  cout_d;
  logic             out_valid_q, out_valid_d;

  // Results load only on a valid transfer and otherwise hold; the valid flag
  // simply follows in_valid each cycle.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum_c;
      carry_d = carry_c;
      cout_d  = chain[LANES];
    end
  end

  // Reset wins over in_valid, discarding any transfer presented with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_approx_compressor_42c.sv
// tb_approx_compressor_42c
//   Self-checking bench for approx_compressor_42c. One single-column instance
//   is driven exhaustively, one eight-column instance with directed and
//   random vectors; both share clock, reset and in_valid.
module tb_approx_compressor_42c;

  logic       clk;
  logic       rst;
  logic       in_valid;

  logic [0:0] x1_a, x2_a, x3_a, x4_a;
  logic       cin_a;
  logic       out_valid_a;
  logic [0:0] sum_a, carry_a;
  logic       cout_a;

  logic [7:0] x1_b, x2_b, x3_b, x4_b;
  logic       cin_b;
  logic       out_valid_b;
  logic [7:0] sum_b, carry_b;
  logic       cout_b;

  int checks   = 0;
  int failures = 0;

  approx_compressor_42c #(.LANES(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x1        (x1_a),
    .x2        (x2_a),
    .x3        (x3_a),
    .x4        (x4_a),
    .cin       (cin_a),
    .out_valid (out_valid_a),
    .sum       (sum_a),
    .carry     (carry_a),
    .cout      (cout_a)
  );

  approx_compressor_42c #(.LANES(8)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x1        (x1_b),
    .x2        (x2_b),
    .x3        (x3_b),
    .x4        (x4_b),
    .cin       (cin_b),
    .out_valid (out_valid_b),
    .sum       (sum_b),
    .carry     (carry_b),
    .cout      (cout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge so outputs are stable.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic randomizeInputs();
    x1_a  = 1'($urandom_range(0, 1));
    x2_a  = 1'($urandom_range(0, 1));
    x3_a  = 1'($urandom_range(0, 1));
    x4_a  = 1'($urandom_range(0, 1));
    cin_a = 1'($urandom_range(0, 1));
    x1_b  = 8'($urandom_range(0, 255));
    x2_b  = 8'($urandom_range(0, 255));
    x3_b  = 8'($urandom_range(0, 255));
    x4_b  = 8'($urandom_range(0, 255));
    cin_b = 1'($urandom_range(0, 1));
  endtask

  // Column-by-column arithmetic reference for the 8-column row: co is the
  // majority of x1..x3, sum is the parity of the five-bit count, and the
  // remaining weight-2 part of the count not taken by co lands in carry.
  task automatic modelRow(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input logic ci,
                          output logic [7:0] s_exp, output logic [7:0] c_exp,
                          output logic co_exp);
    logic lat;
    int   cnt3, tot, co_k;
    lat = ci;
    s_exp = '0;
    c_exp = '0;
    for (int k = 0; k < 8; k++) begin
      cnt3 = int'(a[k]) + int'(b[k]) + int'(c[k]);
      co_k = (cnt3 >= 2) ? 1 : 0;
      tot  = cnt3 + int'(d[k]) + int'(lat);
      s_exp[k] = tot[0];
      c_exp[k] = 1'((tot - int'(tot[0])) / 2 - co_k);
      lat = co_k[0];
    end
    co_exp = lat;
  endtask

  function automatic logic [31:0] rowLhs(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d,
                                         input logic ci);
    return 32'(a) + 32'(b) + 32'(c) + 32'(d) + 32'(ci);
  endfunction

  function automatic logic [31:0] rowRhs(input logic [7:0] s, input logic [7:0] cy,
                                         input logic co);
    return 32'(s) + (32'(cy) << 1) + (32'(co) << 8);
  endfunction

  logic [7:0] exp_sum, exp_carry;
  logic       exp_cout;
  logic [7:0] held_sum, held_carry;
  logic       held_cout;
  logic [7:0] px1, px2, px3, px4;
  logic       pcin;
  logic [4:0] vec;

  initial begin
    // Reset held for two cycles with a live transfer presented.
    rst = 1'b1;
    in_valid = 1'b1;
    randomizeInputs();
    applyStimulus();
    randomizeInputs();
    applyStimulus();
    checkOutput("rst_sum_b",   32'(sum_b),       32'd0);
    checkOutput("rst_carry_b", 32'(carry_b),     32'd0);
    checkOutput("rst_cout_b",  32'(cout_b),      32'd0);
    checkOutput("rst_valid_b", 32'(out_valid_b), 32'd0);
    checkOutput("rst_sum_a",   32'(sum_a),       32'd0);
    checkOutput("rst_valid_a", 32'(out_valid_a), 32'd0);

    // One idle cycle after release: nothing valid yet.
    rst = 1'b0;
    in_valid = 1'b0;
    applyStimulus();
    checkOutput("idle_valid_b", 32'(out_valid_b), 32'd0);

    // Single column, all 32 input combinations against the popcount.
    in_valid = 1'b1;
    for (int v = 0; v < 32; v++) begin
      vec = 5'(v);
      x1_a = vec[0];
      x2_a = vec[1];
      x3_a = vec[2];
      x4_a = vec[3];
      cin_a = vec[4];
      applyStimulus();
      checkOutput("lane1_count",
                  32'(sum_a) + 2 * (32'(carry_a) + 32'(cout_a)),
                  32'(vec[0]) + 32'(vec[1]) + 32'(vec[2]) + 32'(vec[3]) + 32'(vec[4]));
      checkOutput("lane1_valid", 32'(out_valid_a), 32'd1);
    end
    // All-ones column saturates every output bit.
    checkOutput("lane1_ones_sum",   32'(sum_a),   32'd1);
    checkOutput("lane1_ones_carry", 32'(carry_a), 32'd1);
    checkOutput("lane1_ones_cout",  32'(cout_a),  32'd1);

    // Random row vectors, each checked one cycle later.
    for (int n = 0; n < 10000; n++) begin
      randomizeInputs();
      px1 = x1_b; px2 = x2_b; px3 = x3_b; px4 = x4_b; pcin = cin_b;
      applyStimulus();
      modelRow(px1, px2, px3, px4, pcin, exp_sum, exp_carry, exp_cout);
      checkOutput("rand_invariant", rowRhs(sum_b, carry_b, cout_b),
                  rowLhs(px1, px2, px3, px4, pcin));
      checkOutput("rand_sum",   32'(sum_b),       32'(exp_sum));
      checkOutput("rand_carry", 32'(carry_b),     32'(exp_carry));
      checkOutput("rand_cout",  32'(cout_b),      32'(exp_cout));
      checkOutput("rand_valid", 32'(out_valid_b), 32'd1);
    end
    held_sum   = exp_sum;
    held_carry = exp_carry;
    held_cout  = exp_cout;

    // Three idle cycles with changing inputs: results hold, valid drops.
    in_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      randomizeInputs();
      applyStimulus();
      checkOutput("hold_sum",   32'(sum_b),       32'(held_sum));
      checkOutput("hold_carry", 32'(carry_b),     32'(held_carry));
      checkOutput("hold_cout",  32'(cout_b),      32'(held_cout));
      checkOutput("hold_valid", 32'(out_valid_b), 32'd0);
    end

    // Reset together with a transfer: the transfer is discarded.
    rst = 1'b1;
    in_valid = 1'b1;
    x1_b = 8'hFF; x2_b = 8'hFF; x3_b = 8'hFF; x4_b = 8'hFF; cin_b = 1'b1;
    applyStimulus();
    checkOutput("rstpri_sum",   32'(sum_b),       32'd0);
    checkOutput("rstpri_carry", 32'(carry_b),     32'd0);
    checkOutput("rstpri_cout",  32'(cout_b),      32'd0);
    checkOutput("rstpri_valid", 32'(out_valid_b), 32'd0);

    // First transfer after release: full-chain pattern. Every column has
    // x1..x3 set, so every lateral carry is 1; each column counts 4 giving
    // sum 0, carry 1. 3*255+1 = 766 = 2*255 + 256.
    rst = 1'b0;
    x1_b = 8'hFF; x2_b = 8'hFF; x3_b = 8'hFF; x4_b = 8'h00; cin_b = 1'b1;
    applyStimulus();
    checkOutput("chain_valid",     32'(out_valid_b), 32'd1);
    checkOutput("chain_sum",       32'(sum_b),       32'h00);
    checkOutput("chain_carry",     32'(carry_b),     32'hFF);
    checkOutput("chain_cout",      32'(cout_b),      32'd1);
    checkOutput("chain_invariant", rowRhs(sum_b, carry_b, cout_b), 32'd766);

    // Directed: only x4 and cin active, no lateral carries generated.
    x1_b = 8'h00; x2_b = 8'h00; x3_b = 8'h00; x4_b = 8'hA5; cin_b = 1'b1;
    applyStimulus();
    checkOutput("x4_sum",   32'(sum_b),   32'hA4);
    checkOutput("x4_carry", 32'(carry_b), 32'h01);
    checkOutput("x4_cout",  32'(cout_b),  32'd0);

    in_valid = 1'b0;
    applyStimulus();
    checkOutput("final_valid", 32'(out_valid_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
